// File: rtl/prog_clock_divider_pkg.sv
// Shared types and constants for the programmable multi-channel clock divider.
package prog_clock_divider_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUN      = 2'd1,
      ST_STOPPING = 2'd2
   } ch_state_t;

   // A requested half-period below this is treated as this value.
   localparam int unsigned MIN_RATIO = 1;

endpackage

// File: rtl/prog_clock_divider_channel.sv
// One divider channel: half-period counter, glitch-free ratio update, run/stop sequencing.
//
//   state       | meaning
//   ------------+---------------------------------------------------------------
//   ST_IDLE     | output held low, counter cleared, pending ratio applied at once
//   ST_RUN      | dividing; pending ratio applied at each low->high toggle
//   ST_STOPPING | en dropped while high; finish the high phase, then idle
module div_channel
   import prog_clock_divider_pkg::*;
#(
   parameter int CNT_W    = 16,
   parameter int RST_HALF = 5
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   input  logic [CNT_W-1:0] i_div_half,
   input  logic             i_load,
   input  logic             i_sync,
   output logic             o_clk_out,
   output logic             o_tick
);

   localparam logic [CNT_W-1:0] CNT_MIN   = CNT_W'(MIN_RATIO);
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] RST_RATIO = (RST_HALF < int'(MIN_RATIO)) ? CNT_MIN
                                                                         : CNT_W'(RST_HALF);

   ch_state_t        r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_ratio_act;
   logic [CNT_W-1:0] r_ratio_pend;
   logic             r_pend_valid;
   logic             r_clk_q;
   logic             r_tick;

   logic [CNT_W-1:0] w_load_ratio;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             w_terminal;

   assign w_load_ratio = (i_div_half < CNT_MIN) ? CNT_MIN : i_div_half;
   assign w_cnt_inc    = r_cnt + CNT_ONE;
   assign w_terminal   = (r_cnt == r_ratio_act);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_ratio_act  <= RST_RATIO;
         r_ratio_pend <= RST_RATIO;
         r_pend_valid <= 1'b0;
         r_clk_q      <= 1'b0;
         r_tick       <= 1'b0;
      end else begin
         r_tick <= 1'b0;

         if (r_state == ST_IDLE) begin
            r_clk_q <= 1'b0;
            r_cnt   <= '0;
            if (r_pend_valid) begin
               r_ratio_act  <= r_ratio_pend;
               r_pend_valid <= 1'b0;
            end
            if (i_en) begin
               r_state <= ST_RUN;
               r_clk_q <= 1'b1;
               r_tick  <= ~r_clk_q;
               r_cnt   <= CNT_ONE;
            end
         end else if (i_sync) begin
            // Restart the period; a channel already high stays high, so no tick.
            if (r_pend_valid) begin
               r_ratio_act  <= r_ratio_pend;
               r_pend_valid <= 1'b0;
            end
            r_clk_q <= 1'b1;
            r_tick  <= ~r_clk_q;
            r_cnt   <= CNT_ONE;
            r_state <= i_en ? ST_RUN : ST_IDLE;
         end else if (!i_en && !r_clk_q) begin
            r_state <= ST_IDLE;
            r_clk_q <= 1'b0;
            r_cnt   <= '0;
         end else if (w_terminal) begin
            r_cnt <= CNT_ONE;
            if (r_clk_q) begin
               r_clk_q <= 1'b0;
               r_state <= i_en ? ST_RUN : ST_IDLE;
               if (!i_en) begin
                  r_cnt <= '0;
               end
            end else begin
               // Period boundary: the only point a new ratio may take effect.
               r_clk_q <= 1'b1;
               r_tick  <= 1'b1;
               r_state <= ST_RUN;
               if (r_pend_valid) begin
                  r_ratio_act  <= r_ratio_pend;
                  r_pend_valid <= 1'b0;
               end
            end
         end else begin
            r_cnt   <= w_cnt_inc;
            r_state <= i_en ? ST_RUN : ST_STOPPING;
         end

         // Written last so a load on an application edge stays pending.
         if (i_load) begin
            r_ratio_pend <= w_load_ratio;
            r_pend_valid <= 1'b1;
         end
      end
   end

   assign o_clk_out = r_clk_q;
   assign o_tick    = r_tick;

endmodule

// File: rtl/prog_clock_divider.sv
// Programmable clock divider: NUM_CH independent channels sharing load and sync strobes.
module prog_clock_divider
   import prog_clock_divider_pkg::*;
#(
   parameter int NUM_CH   = 4,
   parameter int CNT_W    = 16,
   parameter int RST_HALF = 5
) (
   input  logic                    clk_in,
   input  logic                    rst_n,
   input  logic [NUM_CH-1:0]       en,
   input  logic [NUM_CH*CNT_W-1:0] div_half,
   input  logic                    load,
   input  logic                    sync,
   output logic [NUM_CH-1:0]       clk_out,
   output logic [NUM_CH-1:0]       tick
);

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      div_channel #(
         .CNT_W    (CNT_W),
         .RST_HALF (RST_HALF)
      ) u_ch (
         .i_clk      (clk_in),
         .i_rst_n    (rst_n),
         .i_en       (en[g]),
         .i_div_half (div_half[g*CNT_W +: CNT_W]),
         .i_load     (load),
         .i_sync     (sync),
         .o_clk_out  (clk_out[g]),
         .o_tick     (tick[g])
      );
   end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Self-checking bench: period-position model compared every cycle, plus directed literal checks.
module tb_prog_clock_divider;

   localparam int NUM_CH   = 4;
   localparam int CNT_W    = 16;
   localparam int RST_HALF = 5;

   logic                    clk_in = 1'b0;
   logic                    rst_n;
   logic [NUM_CH-1:0]       en;
   logic [NUM_CH*CNT_W-1:0] div_half;
   logic                    load;
   logic                    sync;
   logic [NUM_CH-1:0]       clk_out;
   logic [NUM_CH-1:0]       tick;

   always #5 clk_in = ~clk_in;

   prog_clock_divider #(
      .NUM_CH   (NUM_CH),
      .CNT_W    (CNT_W),
      .RST_HALF (RST_HALF)
   ) dut (
      .clk_in   (clk_in),
      .rst_n    (rst_n),
      .en       (en),
      .div_half (div_half),
      .load     (load),
      .sync     (sync),
      .clk_out  (clk_out),
      .tick     (tick)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int eff(input int v);
      return (v < 1) ? 1 : v;
   endfunction

   // Model: each running channel is a position within a period of 2*ratio cycles;
   // the output is high for the first half of the period.
   int m_ratio [NUM_CH];
   int m_pend  [NUM_CH];
   int m_pos   [NUM_CH];
   bit m_pv    [NUM_CH];
   bit m_run   [NUM_CH];
   bit m_clk   [NUM_CH];
   bit m_tick  [NUM_CH];

   always @(posedge clk_in) begin : model
      for (int i = 0; i < NUM_CH; i++) begin
         bit nclk;
         if (!rst_n) begin
            m_run[i]   = 1'b0;
            m_pos[i]   = 0;
            m_ratio[i] = eff(RST_HALF);
            m_pend[i]  = eff(RST_HALF);
            m_pv[i]    = 1'b0;
         end else begin
            if (!m_run[i]) begin
               if (m_pv[i]) begin m_ratio[i] = m_pend[i]; m_pv[i] = 1'b0; end
               if (en[i]) begin m_run[i] = 1'b1; m_pos[i] = 0; end
            end else if (sync) begin
               if (m_pv[i]) begin m_ratio[i] = m_pend[i]; m_pv[i] = 1'b0; end
               m_pos[i] = 0;
               m_run[i] = en[i];
            end else if (!en[i] && m_pos[i] >= m_ratio[i]) begin
               m_run[i] = 1'b0;
            end else begin
               m_pos[i]++;
               if (m_pos[i] == 2 * m_ratio[i]) begin
                  m_pos[i] = 0;
                  if (m_pv[i]) begin m_ratio[i] = m_pend[i]; m_pv[i] = 1'b0; end
               end
               if (!en[i] && m_pos[i] == m_ratio[i]) m_run[i] = 1'b0;
            end
            if (load) begin
               m_pend[i] = eff(int'(div_half[i*CNT_W +: CNT_W]));
               m_pv[i]   = 1'b1;
            end
         end
         if (!m_run[i]) m_pos[i] = 0;
         nclk      = m_run[i] && (m_pos[i] < m_ratio[i]);
         m_tick[i] = nclk && !m_clk[i];
         m_clk[i]  = nclk;
      end
   end

   bit cmp_en = 1'b0;
   int cyc_n  = 0;
   int last_tick   [NUM_CH];
   int last_period [NUM_CH];

   always @(negedge clk_in) begin : compare
      cyc_n++;
      for (int i = 0; i < NUM_CH; i++) begin
         if (cmp_en) begin
            check($sformatf("clk_out[%0d] vs model", i), 32'(clk_out[i]), 32'(m_clk[i]));
            check($sformatf("tick[%0d] vs model", i), 32'(tick[i]), 32'(m_tick[i]));
         end
         if (tick[i] === 1'b1) begin
            last_period[i] = cyc_n - last_tick[i];
            last_tick[i]   = cyc_n;
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(negedge clk_in);
         #1;
      end
   endtask

   task automatic wait_tick(input int ch, input int budget);
      int k = 0;
      do begin
         cyc(1);
         k++;
      end while (tick[ch] !== 1'b1 && k < budget);
      check($sformatf("tick[%0d] within %0d cycles", ch, budget), 32'(tick[ch]), 32'd1);
   endtask

   initial begin
      rst_n    = 1'b0;
      en       = '0;
      div_half = '0;
      load     = 1'b0;
      sync     = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         last_tick[i]   = 0;
         last_period[i] = 0;
      end

      cyc(3);
      cmp_en = 1'b1;
      check("reset clk_out", 32'(clk_out), 32'd0);
      check("reset tick", 32'(tick), 32'd0);
      rst_n = 1'b1;
      cyc(2);
      check("idle clk_out", 32'(clk_out), 32'd0);

      // Four ratios, enable all channels together.
      div_half = {16'd3, 16'd2, 16'd1, 16'd5};
      load = 1'b1; cyc(1); load = 1'b0;
      cyc(1);
      en = 4'hF;
      cyc(1);
      check("start clk_out", 32'(clk_out), 32'hF);
      check("start tick", 32'(tick), 32'hF);
      cyc(30);
      check("period ch0", last_period[0], 10);
      check("period ch1", last_period[1], 2);
      check("period ch2", last_period[2], 4);
      check("period ch3", last_period[3], 6);
      wait_tick(3, 20);
      cyc(2);
      check("ch3 high cycle 3", 32'(clk_out[3]), 32'd1);
      cyc(1);
      check("ch3 low after 3", 32'(clk_out[3]), 32'd0);

      // Stop two cycles into a high phase, then restart.
      wait_tick(0, 30);
      cyc(1);
      en[0] = 1'b0;
      cyc(3);
      check("stopping holds high", 32'(clk_out[0]), 32'd1);
      cyc(1);
      check("stopped low", 32'(clk_out[0]), 32'd0);
      cyc(6);
      check("stopped stays low", 32'(clk_out[0]), 32'd0);
      en[0] = 1'b1;
      cyc(1);
      check("re-enable high", 32'(clk_out[0]), 32'd1);
      check("re-enable tick", 32'(tick[0]), 32'd1);

      // Ratio change mid-high-phase takes effect at the next period boundary.
      wait_tick(0, 30);
      cyc(2);
      div_half = {16'd3, 16'd2, 16'd1, 16'd2};
      load = 1'b1; cyc(1); load = 1'b0;
      wait_tick(0, 30);
      check("old period completes", last_period[0], 10);
      wait_tick(0, 30);
      check("new period", last_period[0], 4);

      // Ratio 0 behaves as 1.
      div_half = {16'd3, 16'd2, 16'd1, 16'd0};
      load = 1'b1; cyc(1); load = 1'b0;
      wait_tick(0, 30);
      wait_tick(0, 30);
      check("ratio 0 period", last_period[0], 2);

      // Load on the same edge as a rising toggle waits one more period.
      for (int k = 0; k < 4 && clk_out[0] !== 1'b0; k++) cyc(1);
      check("ch0 low before coincident load", 32'(clk_out[0]), 32'd0);
      div_half = {16'd3, 16'd2, 16'd1, 16'd3};
      load = 1'b1; cyc(1); load = 1'b0;
      check("coincident rise tick", 32'(tick[0]), 32'd1);
      wait_tick(0, 30);
      check("coincident load not applied", last_period[0], 2);
      wait_tick(0, 30);
      check("coincident load applied later", last_period[0], 6);

      // Offset channels 1 and 2 at ratio 3, then realign with sync.
      en = 4'b1001;
      cyc(10);
      div_half = {16'd3, 16'd3, 16'd3, 16'd3};
      load = 1'b1; cyc(1); load = 1'b0;
      cyc(2);
      check("ch1/ch2 idle", 32'(clk_out[2:1]), 32'd0);
      en[1] = 1'b1;
      cyc(1);
      check("ch1 started", 32'(clk_out[1]), 32'd1);
      en[2] = 1'b1;
      cyc(4);
      check("ch1/ch2 both low before sync", 32'(clk_out[2:1]), 32'd0);
      sync = 1'b1; cyc(1); sync = 1'b0;
      check("sync clk_out ch1/ch2", 32'(clk_out[2:1]), 32'd3);
      check("sync tick ch1/ch2", 32'(tick[2:1]), 32'd3);
      wait_tick(1, 20);
      check("ch1 period after sync", last_period[1], 6);
      check("ch2 aligned to ch1", 32'(tick[2]), 32'd1);

      // Reset mid-high-phase.
      wait_tick(0, 30);
      cyc(1);
      rst_n = 1'b0;
      cyc(1);
      check("mid reset clk_out", 32'(clk_out), 32'd0);
      check("mid reset tick", 32'(tick), 32'd0);
      rst_n = 1'b1;
      wait_tick(0, 10);
      wait_tick(0, 30);
      check("ratio reverts to reset value", last_period[0], 10);

      cyc(5);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/prog_clock_divider.md
PROG_CLOCK_DIVIDER -- requirements
Module: prog_clock_divider

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent divider channels.
REQ-002 Parameter CNT_W, default 16: width of the per-channel half-period count.
REQ-003 Parameter RST_HALF, default 5: half-period count loaded into every channel at reset.
REQ-004 clk_in  input  1  sole clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset; synchronous, active-low.
REQ-006 en  input  NUM_CH  per-channel run enable, level-sensitive.
REQ-007 div_half  input  NUM_CH*CNT_W  requested half-period count; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-008 load  input  1  one-cycle strobe; captures div_half for all channels.
REQ-009 sync  input  1  one-cycle strobe; phase-realigns all enabled channels.
REQ-010 clk_out  output  NUM_CH  divided clocks, registered.
REQ-011 tick  output  NUM_CH  one-cycle pulse, registered, coincident with each clk_out rising edge.

Function
REQ-012 Each channel SHALL hold: cnt[CNT_W], ratio_act, ratio_pend, pend_valid, clk_q, and a state in {IDLE, RUN, STOPPING}.
REQ-013 Effective ratio SHALL be max(ratio, 1); a div_half value of 0 behaves as 1.
REQ-014 In RUN/STOPPING, cnt SHALL increment each cycle; when cnt == ratio_act, clk_q toggles and cnt <= 1, giving a high phase of ratio_act cycles, a low phase of ratio_act cycles, and a period of 2*ratio_act.
REQ-015 On load, ratio_pend SHALL capture the channel's slice and pend_valid <= 1; a second load before application overwrites ratio_pend.
REQ-016 A pending ratio SHALL be applied only at a low->high toggle (period boundary): ratio_act <= ratio_pend and pend_valid <= 0; no partial-period glitch occurs.
REQ-017 A load in the same cycle as a low->high toggle SHALL NOT apply at that toggle; it applies at the next period boundary.
REQ-018 IDLE: clk_q = 0 and cnt = 0; any pending ratio is applied immediately. When en = 1, the next state is RUN with clk_q <= 1, tick <= 1, cnt <= 1.
REQ-019 RUN: when en = 0 and clk_q = 1, the next state is STOPPING; when en = 0 and clk_q = 0, the next state is IDLE at once.
REQ-020 STOPPING: the channel completes the current high phase, then goes to IDLE at the high->low toggle. en re-asserted during STOPPING returns the channel to RUN without disturbing the phase.
REQ-021 On sync, each channel in RUN or STOPPING SHALL restart next cycle (clk_q <= 1, tick <= 1, cnt <= 1, state RUN if en = 1, else IDLE), applying any pending ratio first. IDLE channels ignore sync.
REQ-022 Priority SHALL be rst_n > sync > pending-ratio application > normal count.
REQ-023 tick[i] SHALL be high for exactly the one cycle in which clk_out[i] transitions 0 -> 1, and low at all other times.
REQ-024 Channels SHALL be fully independent except for the shared load and sync strobes.

Reset
REQ-025 While rst_n = 0 at a clk_in edge, every channel SHALL go to: state IDLE, clk_out = 0, tick = 0, cnt = 0, ratio_act = ratio_pend = RST_HALF, pend_valid = 0.
REQ-026 Reset asserted mid-period SHALL abort the period immediately with no completion of the high phase; the first edge after release follows REQ-018.

Structure
REQ-027 The shared package SHALL hold the channel-state enumeration (IDLE, RUN, STOPPING) and the min-ratio constant (1).
REQ-028 One sub-module, div_channel, SHALL implement a single channel and be instantiated NUM_CH times by a generate loop; the top level only slices the buses.

Verification
REQ-029 NUM_CH=4, CNT_W=16; after reset, load div_half = {3,2,1,5} with en = 4'hF -> channel periods of 10/2/4/6 cycles, 50 % duty, tick once per period.
REQ-030 Channel 0 running at ratio 5; load 2 mid-high-phase -> the current period completes at 5+5 cycles, then the period becomes 4 cycles, with no runt pulse.
REQ-031 Deassert en[0] two cycles into a 5-cycle high phase -> clk_out[0] stays high 3 more cycles, then goes low and holds; re-enable -> high on the next cycle with tick.
REQ-032 Two channels at ratio 3 with offset phase; pulse sync -> both clk_out rise on the same cycle with tick asserted on both.
REQ-033 Load 0 -> channel toggles every cycle (period 2); load coincident with a rising toggle -> applied one period later.
REQ-034 Assert rst_n = 0 mid-high-phase -> next edge gives clk_out = 0, tick = 0, and ratio reverts to RST_HALF.
